// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   md_op[2:0]        - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   src_a, src_b      - forwarded rs/rt operands
//   rd_hi             - md_rdata selects HI when 1, LO when 0
//   busy              - calculation in flight
//   stall_req         - busy or a mult/div op presented this cycle
//   md_rdata          - combinational HI/LO read
//   hi, lo            - architectural HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_hi,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] p_hi_q, p_lo_q, hi_q, lo_q;
    logic        dz_q;
    logic        start, is_signed, is_mul, b_nz;
    logic [63:0] ext_a, ext_b, div_b, prod;
    logic signed [63:0] sa, sb;
    logic [31:0] quo, rem, res_hi_d, res_lo_d;
    assign start     = (md_op != 3'd0) && (md_op <= 3'd4);
    assign is_signed = (md_op == 3'd1) || (md_op == 3'd3);
    assign is_mul    = (md_op == 3'd1) || (md_op == 3'd2);
    assign b_nz      = src_b != 32'd0;
    // Operands are widened to 64 bits so one multiplier and one signed divider
    // cover both signednesses; -2^31 / -1 cannot overflow at this width.
    assign ext_a = is_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
    assign ext_b = is_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
    assign div_b = b_nz ? ext_b : 64'd1;
    assign prod  = ext_a * ext_b;
    assign sa    = ext_a;
    assign sb    = div_b;
    assign quo   = is_signed ? 32'(sa / sb) : 32'(ext_a / div_b);
    assign rem   = is_signed ? 32'(sa % sb) : 32'(ext_a % div_b);
    assign res_hi_d = is_mul ? prod[63:32] : rem;
    assign res_lo_d = is_mul ? prod[31:0]  : quo;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            dz_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start) begin
                p_hi_q  <= res_hi_d;
                p_lo_q  <= res_lo_d;
                cnt_q   <= is_mul ? 6'(MULT_CYCLES) : 6'(DIV_CYCLES);
                dz_q    <= !is_mul && !b_nz;
                state_q <= RUN;
            end else if (md_op == 3'd5) begin
                hi_q <= src_a;
            end else if (md_op == 3'd6) begin
                lo_q <= src_a;
            end
        end else begin
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
                state_q <= IDLE;
                if (!dz_q) begin
                    hi_q <= p_hi_q;
                    lo_q <= p_lo_q;
                end
            end
        end
    end
    assign busy      = state_q == RUN;
    assign stall_req = busy || start;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign md_rdata  = rd_hi ? hi_q : lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized self-checking bench for md_unit against an arithmetic HI/LO model.
module tb_md_unit;
    logic        clk = 1'b0, rst_n = 1'b0, rd_hi = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] src_a = 32'd0, src_b = 32'd0;
    logic        busy, stall_req;
    logic [31:0] md_rdata, hi, lo;
    int total = 0, bad = 0;
    logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

    md_unit dut (
        .clk(clk), .rst_n(rst_n), .md_op(md_op), .src_a(src_a), .src_b(src_b),
        .rd_hi(rd_hi), .busy(busy), .stall_req(stall_req), .md_rdata(md_rdata),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic int lat(input logic [2:0] op);
        return (op == 3'd1 || op == 3'd2) ? 5 : (op == 3'd3 || op == 3'd4) ? 10 : 0;
    endfunction

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd2: begin u = {32'd0, a} * {32'd0, b}; hi_m = u[63:32]; lo_m = u[31:0]; end
            3'd3: if (b != 0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
            3'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    // Presents one op at a negedge, then counts busy / stall_req cycles until idle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int bn, output int sn);
        md_op = op; src_a = a; src_b = b; bn = 0;
        #1 sn = int'(stall_req);
        @(negedge clk);
        md_op = 3'd0;
        while (busy && bn < 100) begin
            bn++;
            sn += int'(stall_req);
            @(negedge clk);
        end
        model(op, a, b);
    endtask

    task automatic test_reset;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
        total++; if (md_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", md_rdata); end
        md_op = 3'd3;
        #1;
        total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL reset_stall_op got=%b exp=1", stall_req); end
        md_op = 3'd0;
        #1;
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall_idle got=%b exp=0", stall_req); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int bn, sn;
        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, bn, sn);
        total++; if (bn != 5) begin bad++; $display("FAIL mult_busy got=%0d exp=5", bn); end
        total++; if (sn != 6) begin bad++; $display("FAIL mult_stall got=%0d exp=6", sn); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_lo got=%h exp=fffffff1", lo); end
    endtask

    task automatic test_multu_div;
        int bn, sn;
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, bn, sn);
        total++; if (bn != 5) begin bad++; $display("FAIL multu_busy got=%0d exp=5", bn); end
        total++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_res got=%h/%h exp=00000001/fffffffe", hi, lo); end
        // Starts on the very cycle after the commit edge: back-to-back issue.
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, bn, sn);
        total++; if (bn != 10) begin bad++; $display("FAIL div_busy got=%0d exp=10", bn); end
        total++; if (sn != 11) begin bad++; $display("FAIL div_stall got=%0d exp=11", sn); end
        total++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_res got=%h/%h exp=ffffffff/fffffffd", hi, lo); end
    endtask

    task automatic test_div0;
        int bn, sn;
        run_op(3'd5, 32'h1111_1111, 32'd0, bn, sn);
        run_op(3'd6, 32'h2222_2222, 32'd0, bn, sn);
        run_op(3'd4, 32'd7, 32'd0, bn, sn);
        total++; if (bn != 10) begin bad++; $display("FAIL div0_busy got=%0d exp=10", bn); end
        total++; if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin bad++; $display("FAIL div0_hilo got=%h/%h exp=11111111/22222222", hi, lo); end
    endtask

    task automatic test_mthi_ignored;
        int bn, sn, n;
        md_op = 3'd1; src_a = 32'h0001_2345; src_b = 32'h0010_0000;
        @(negedge clk);
        md_op = 3'd5; src_a = 32'h1234_5678;
        #1;
        total++; if (busy !== 1'b1 || stall_req !== 1'b1) begin bad++; $display("FAIL run_flags got=%b%b exp=11", busy, stall_req); end
        repeat (2) @(negedge clk);
        md_op = 3'd0;
        n = 0;
        while (busy && n < 100) begin n++; @(negedge clk); end
        model(3'd1, 32'h0001_2345, 32'h0010_0000);
        total++; if (hi !== hi_m || lo !== lo_m) begin bad++; $display("FAIL mthi_ignored got=%h/%h exp=%h/%h", hi, lo, hi_m, lo_m); end
        run_op(3'd6, 32'hABCD_0000, 32'd0, bn, sn);
        total++; if (lo !== 32'hABCD_0000 || bn != 0 || sn != 0 || busy !== 1'b0) begin bad++; $display("FAIL mtlo got=%h busy=%0d stall=%0d exp=abcd0000 0 0", lo, bn, sn); end
    endtask

    task automatic test_rdata;
        int n;
        logic [31:0] oh, ol;
        oh = hi_m; ol = lo_m;
        md_op = 3'd2; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_1234;
        @(negedge clk);
        md_op = 3'd0;
        rd_hi = 1'b1;
        #1;
        total++; if (md_rdata !== oh) begin bad++; $display("FAIL rdata_run_hi got=%h exp=%h", md_rdata, oh); end
        rd_hi = 1'b0;
        #1;
        total++; if (md_rdata !== ol) begin bad++; $display("FAIL rdata_run_lo got=%h exp=%h", md_rdata, ol); end
        n = 0;
        while (busy && n < 100) begin n++; @(negedge clk); end
        model(3'd2, 32'hDEAD_BEEF, 32'h0000_1234);
        rd_hi = 1'b1;
        #1;
        total++; if (md_rdata !== hi_m) begin bad++; $display("FAIL rdata_hi got=%h exp=%h", md_rdata, hi_m); end
        rd_hi = 1'b0;
        #1;
        total++; if (md_rdata !== lo_m) begin bad++; $display("FAIL rdata_lo got=%h exp=%h", md_rdata, lo_m); end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        int seen;
        md_op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        md_op = 3'd0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL async_rst got=%b %h/%h exp=0 0/0", busy, hi, lo); end
        @(negedge clk);
        rst_n = 1'b1;
        hi_m = 32'd0; lo_m = 32'd0;
        seen = 0;
        repeat (15) begin @(negedge clk); seen += int'(busy); end
        total++; if (seen != 0 || hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL no_commit got=%0d %h/%h exp=0 0/0", seen, hi, lo); end
    endtask

    task automatic test_random;
        int bn, sn;
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(1, 6));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
            run_op(op, a, b, bn, sn);
            total++; if (bn != lat(op) || sn != ((lat(op) == 0) ? 0 : lat(op) + 1)) begin bad++; $display("FAIL rnd_timing op=%0d got=%0d/%0d exp=%0d", op, bn, sn, lat(op)); end
            total++; if (hi !== hi_m || lo !== lo_m) begin bad++; $display("FAIL rnd_res op=%0d a=%h b=%h got=%h/%h exp=%h/%h", op, a, b, hi, lo, hi_m, lo_m); end
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_multu_div;
        test_div0;
        test_mthi_ignored;
        test_rdata;
        test_async_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
